// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch front end.
package fetch_pkg;

   // One queued fetch result: the PC it was fetched from and the instruction word.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } iq_entry_t;

   // IDLE: nothing outstanding. WAIT: response kept. WAIT_DROP: response discarded.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT      = 2'd1,
      WAIT_DROP = 2'd2
   } fetch_state_t;

   localparam logic [3:0] FETCH_RMASK = 4'hF;

   // Saturating increment for 32-bit event counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched instructions; flush beats push and pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  iq_entry_t        push_data,
   input  logic             pop,
   output logic             valid,
   output iq_entry_t        head,
   output logic [PTR_W:0]   count
);

   iq_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             full, push_ok, pop_ok;

   // Qualify push/pop against occupancy so the pointers can never pass each other.
   always_comb begin
      full    = (count_q == (PTR_W+1)'(DEPTH));
      push_ok = push && !full;
      pop_ok  = pop && (count_q != '0);
      count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
      valid   = (count_q != '0);
      head    = mem_q[rd_ptr_q];
      count   = count_q;
   end

   // Pointer and occupancy state; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningless outside the valid window so no reset.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: sequential-PC fetch with one outstanding icache request and an
// instruction queue for decode. Optional perf counters: define FETCH_PERF_CNT_EN.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned IQ_DEPTH = 8,
   parameter logic [31:0] RESET_PC = 32'h1ECE_B000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] cpu_ufp_addr,
   output logic [3:0]  cpu_ufp_rmask,
   input  logic [31:0] ufp_rdata,
   input  logic        ufp_resp,
   output logic        deq_valid,
   input  logic        deq_ready,
   output logic [31:0] deq_instr,
   output logic [31:0] deq_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_req_cnt,
   output logic [31:0] perf_full_cnt,
   output logic [31:0] perf_drop_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(IQ_DEPTH);

   fetch_state_t   state_q, state_d;
   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [31:0]    pend_pc_q, pend_pc_d;
   logic [PTR_W:0] iq_count;
   iq_entry_t      iq_head, push_data;
   logic           push, pop, drop, issue, room, iq_valid;

   // Request/enqueue decisions. Pop is left out of the room check so deq_ready
   // has no combinational path to the request.
   always_comb begin
      push      = ufp_resp && (state_q == WAIT) && !redirect_valid;
      drop      = ufp_resp && ((state_q == WAIT_DROP) || ((state_q == WAIT) && redirect_valid));
      room      = (32'(iq_count) + 32'(push)) < IQ_DEPTH;
      issue     = !rst && ((state_q == IDLE) || ufp_resp) && !redirect_valid && room;
      pop       = iq_valid && deq_ready;
      push_data = '{pc: pend_pc_q, instr: ufp_rdata};
      cpu_ufp_rmask = issue ? FETCH_RMASK : 4'h0;
      cpu_ufp_addr  = issue ? fetch_pc_q : 32'h0;
      deq_valid = iq_valid;
      deq_instr = iq_head.instr;
      deq_pc    = iq_head.pc;
   end

   // Next state and PC registers; redirect takes priority over everything else.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         case (state_q)
            WAIT, WAIT_DROP: state_d = ufp_resp ? IDLE : WAIT_DROP;
            default:         state_d = IDLE;
         endcase
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         pend_pc_d  = fetch_pc_q;
         state_d    = WAIT;
      end else if (ufp_resp && (state_q != IDLE)) begin
         state_d = IDLE;
      end
   end

   // FSM and PC state; a response arriving in IDLE falls through untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         pend_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_pc_q  <= pend_pc_d;
      end
   end

   fetch_queue #(
      .DEPTH (IQ_DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .valid     (iq_valid),
      .head      (iq_head),
      .count     (iq_count)
   );

`ifdef FETCH_PERF_CNT_EN
   logic full_stall;

   // Cycles where the fetcher is free but the queue alone blocks the request.
   always_comb begin
      full_stall = (state_q == IDLE) && !redirect_valid && !room;
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_req_cnt  <= '0;
         perf_full_cnt <= '0;
         perf_drop_cnt <= '0;
      end else begin
         if (issue)      perf_req_cnt  <= sat_inc(perf_req_cnt);
         if (full_stall) perf_full_cnt <= sat_inc(perf_full_cnt);
         if (drop)       perf_drop_cnt <= sat_inc(perf_drop_cnt);
      end
   end
`else
   logic unused_drop;
   always_comb unused_drop = drop;
`endif

endmodule
